alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU.
// Each operation runs as IDLE -> EXEC -> RESP, and its tagged response waits until it is consumed.
module alu_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_r,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [31:0]      x_q, y_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic             rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_err_q;
    logic [31:0]      rsp_r_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    logic             any_valid, grant_id, accept, handshake;
    logic [31:0]      alu_r;
    logic             alu_err;

    assign any_valid = req0_valid | req1_valid;
    // A tie goes to whichever requester was not granted last.
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept    = (state_q == StIdle) && any_valid;
    assign handshake = (state_q == StResp) && rsp_ready;

    // Gated by rst_n so neither requester sees ready while reset is held.
    assign req0_ready = rst_n && accept && !grant_id;
    assign req1_ready = rst_n && accept && grant_id;

    always_comb begin
        alu_r   = 32'h0;
        alu_err = 1'b0;
        case (op_q)
            4'd0:    alu_r = x_q & y_q;
            4'd1:    alu_r = x_q | y_q;
            4'd2:    alu_r = x_q + y_q;
            4'd6:    alu_r = x_q - y_q;
            4'd7:    alu_r = {31'h0, $signed(x_q) < $signed(y_q)};
            4'd12:   alu_r = ~(x_q | y_q);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            x_q          <= 32'h0;
            y_q          <= 32'h0;
            op_q         <= 4'h0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_r_q      <= 32'h0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            if (accept) begin
                x_q          <= grant_id ? req1_x : req0_x;
                y_q          <= grant_id ? req1_y : req0_y;
                op_q         <= grant_id ? req1_op : req0_op;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == StExec) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_r_q     <= alu_r;
                rsp_err_q   <= alu_err;
                rsp_zero_q  <= !alu_err && (alu_r == 32'h0);
            end
            if (handshake) begin
                rsp_valid_q <= 1'b0;
                if (rsp_id_q) cnt1_q <= cnt1_q + CNT_W'(1);
                else          cnt0_q <= cnt0_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (CNT_W=4 so that counter wrap is reachable).
// Every expected value is hand-computed from the operation definitions.
module tb_alu_arbiter;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]   req0_x, req0_y, req1_x, req1_y;
    logic [3:0]    req0_op, req1_op;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [31:0]   rsp_r;
    logic [CW-1:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT idle; leaves it idle again.
    task automatic run_op(input logic id, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] op, input logic [31:0] er, input logic ez,
                          input logic ee);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_op = op;
        end
        #1;
        chk("grant", id ? req1_ready : req0_ready, 1);
        chk("no_grant_other", id ? req0_ready : req1_ready, 0);
        step();
        // Scramble the payload after acceptance; the in-flight result must not change.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = ~x; req1_x = ~x; req0_op = 4'd1; req1_op = 4'd1;
        #1;
        chk("exec_ready0", req0_ready, 0);
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
        step();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_r", rsp_r, er);
        chk("rsp_zero", rsp_zero, ez);
        chk("rsp_err", rsp_err, ee);
        step();
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    initial begin
        logic [CW-1:0] c1;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x = '0; req0_y = '0; req0_op = '0;
        req1_x = '0; req1_y = '0; req1_op = '0;
        #12;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_r", rsp_r, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_flags", {rsp_zero, rsp_err}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnts", {cnt0, cnt1}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #10 rst_n = 1'b1;
        step();

        // Single ADD from requester 0.
        run_op(1'b0, 32'd5, 32'd7, 4'd2, 32'd12, 1'b0, 1'b0);
        chk("add_cnt0", cnt0, 1);
        chk("add_cnt1", cnt1, 0);

        // Fresh reset so the first tie goes to requester 0.
        rst_n = 1'b0; #2 rst_n = 1'b1;
        step();
        req0_valid = 1'b1; req0_x = 32'd9;    req0_y = 32'd9;    req0_op = 4'd6;
        req1_valid = 1'b1; req1_x = 32'hF0;   req1_y = 32'h0F;   req1_op = 4'd1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_ready0", req0_ready, (i % 2) == 0);
            chk("tie_ready1", req1_ready, (i % 2) == 1);
            step();
            step();
            chk("tie_rsp_id", rsp_id, i % 2);
            chk("tie_rsp_r", rsp_r, (i % 2) ? 32'hFF : 32'h0);
            chk("tie_rsp_zero", rsp_zero, (i % 2) == 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_cnts", {cnt0, cnt1}, {4'd2, 4'd2});

        // Backpressure with requester 0 waiting the whole time.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_x = 32'hFF00FF00; req1_y = 32'h0FF00FF0; req1_op = 4'd0;
        step();
        req1_valid = 1'b0; req1_x = 32'h0;
        req0_valid = 1'b1; req0_x = 32'h0; req0_y = 32'h0; req0_op = 4'd12;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_r", rsp_r, 32'h0F000F00);
            chk("bp_id", rsp_id, 1);
            chk("bp_ready", {req0_ready, req1_ready}, 0);
            chk("bp_cnt1", cnt1, 2);
            step();
        end
        rsp_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_cnt1", cnt1, 3);
        step();
        chk("bp_no_double", cnt1, 3);
        chk("bp_idle", busy, 0);

        // Edge-case op codes.
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 4'd7, 32'd1, 1'b0, 1'b0);
        run_op(1'b0, 32'd1, 32'hFFFFFFFF, 4'd7, 32'd0, 1'b1, 1'b0);
        run_op(1'b0, 32'h0, 32'h0, 4'd12, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 4'd2, 32'd0, 1'b1, 1'b0);
        run_op(1'b0, 32'h12345678, 32'h1, 4'd3, 32'd0, 1'b0, 1'b1);
        chk("edge_cnt0", cnt0, 7);

        // Reset while a response is held.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_x = 32'd3; req1_y = 32'd4; req1_op = 4'd2;
        step();
        req1_valid = 1'b0;
        step();
        chk("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_cnts", {cnt0, cnt1}, 0);
        chk("mid_rst_busy", busy, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);

        // Counter wrap on requester 1.
        for (int i = 0; i < 16; i++) begin
            run_op(1'b1, i, 32'd1, 4'd2, i + 1, 1'b0, 1'b0);
            c1 = CW'(i + 1);
            if (i == 14) chk("wrap_cnt1_15", cnt1, 15);
            if (i == 15) chk("wrap_cnt1_0", cnt1, c1);
        end
        chk("wrap_cnt0", cnt0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
